// File: rtl/pipelined_shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Op encoding and per-stage shift distance.
package shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_t;

    function automatic int stage_dist(input int k);
        return 1 << k;
    endfunction

endpackage

// File: rtl/pipelined_shifter_stage.sv
// One combinational log2 stage of the barrel shifter: shifts by 2^K when en.
// Rotate path exists only when PIPELINED_SHIFTER_ROTATE_EN is defined.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int N = 32,
    parameter int K = 0
) (
    input  logic [N-1:0] din,
    input  logic         en,
    input  shift_op_t    op,
    output logic [N-1:0] dout
);

    localparam int D = stage_dist(K);

    logic [N-1:0] sll;
    logic [N-1:0] srl;
    logic [N-1:0] sra;
    logic [N-1:0] ror;

    assign sll = din << D;
    assign srl = din >> D;
    assign sra = $signed(din) >>> D;

`ifdef PIPELINED_SHIFTER_ROTATE_EN
    assign ror = {din[D-1:0], din[N-1:D]};
`else
    // Without rotate support op 11 behaves as a logical right shift.
    assign ror = srl;
`endif

    always_comb begin
        dout = din;
        if (en) begin
            unique case (op)
                SHIFT_SLL: dout = sll;
                SHIFT_SRL: dout = srl;
                SHIFT_SRA: dout = sra;
                SHIFT_ROR: dout = ror;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Fully pipelined barrel shifter, one register per log2 stage, valid/ready on both sides.
// Optional rotate-right enabled by PIPELINED_SHIFTER_ROTATE_EN.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_shamt,
    input  logic [1:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data
);

    localparam int S = $clog2(N);

    generate
        if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_width
            $error("pipelined_shifter: N must be a power of two >= 2");
        end
    endgenerate

    logic            stall;
    logic            vld  [S];
    logic [N-1:0]    dat  [S];
    logic [S-1:0]    sh   [S];
    shift_op_t       op   [S];

    logic            vin  [S];
    logic [N-1:0]    sin  [S];
    logic [S-1:0]    shin [S];
    shift_op_t       opin [S];
    logic [N-1:0]    sout [S];

    // Global hold: a blocked output freezes every stage.
    assign stall     = vld[S-1] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld[S-1];
    assign out_data  = dat[S-1];

    genvar k;
    generate
        for (k = 0; k < S; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign vin[k]  = in_valid;
                assign sin[k]  = in_data;
                assign shin[k] = in_shamt;
                assign opin[k] = shift_op_t'(in_op);
            end else begin : g_body
                assign vin[k]  = vld[k-1];
                assign sin[k]  = dat[k-1];
                assign shin[k] = sh[k-1];
                assign opin[k] = op[k-1];
            end

            shift_stage #(
                .N (N),
                .K (k)
            ) u_stage (
                .din  (sin[k]),
                .en   (shin[k][k]),
                .op   (opin[k]),
                .dout (sout[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < S; i++) begin
                vld[i] <= 1'b0;
                dat[i] <= '0;
                sh[i]  <= '0;
                op[i]  <= SHIFT_SLL;
            end
        end else if (!stall) begin
            for (int i = 0; i < S; i++) begin
                vld[i] <= vin[i];
                dat[i] <= sout[i];
                sh[i]  <= shin[i];
                op[i]  <= opin[i];
            end
        end
    end

    // Shamt and op of the final stage have no consumer downstream.
    logic unused_tail;
    assign unused_tail = ^{sh[S-1], op[S-1]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter (N=32 and N=8 instances).
// Follows PIPELINED_SHIFTER_ROTATE_EN for the expected rotate behaviour.
module tb_pipelined_shifter;
    import shifter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;

    logic        v8, r8, ov8, ordy8;
    logic [7:0]  d8, od8;
    logic [2:0]  sh8;
    logic [1:0]  op8;

    always #5 clk = ~clk;

    pipelined_shifter #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    pipelined_shifter #(.N(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .in_ready  (r8),
        .in_data   (d8),
        .in_shamt  (sh8),
        .in_op     (op8),
        .out_valid (ov8),
        .out_ready (ordy8),
        .out_data  (od8)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  sh;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [12];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] q [$];
    logic [31:0] cur_exp;
    logic [31:0] held;
    bit          acc;
    int          streak, best;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d,
                                          input logic [4:0] s,
                                          input logic [1:0] o);
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return $signed(d) >>> s;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
            default: return (d >> s) | (d << (32 - int'(s)));
`else
            default: return d >> s;
`endif
        endcase
    endfunction

    // Sample at negedge, then advance to just after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            streak++;
            if (streak > best) best = streak;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got %h required none", out_data);
            end else begin
                check("result", out_data, q.pop_front());
            end
        end else begin
            streak = 0;
        end
        if (acc) q.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] o, input logic [31:0] e);
        int n;
        in_data  = d;
        in_shamt = s;
        in_op    = o;
        cur_exp  = e;
        in_valid = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!acc && n < 1000);
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no accept required accept");
        end
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            cycle();
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    task automatic latency_test(input string name, input logic [31:0] d,
                                input logic [4:0] s, input logic [1:0] o,
                                input logic [31:0] e);
        int lat;
        send(d, s, o, e);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            cycle();
            lat++;
        end
        check(name, lat, 5);
        drain();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        int lat, seen;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0;
        out_ready = 1'b1;
        v8 = 1'b0; d8 = '0; sh8 = '0; op8 = '0; ordy8 = 1'b1;
        streak = 0; best = 0; cur_exp = '0;

        tbl[0]  = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF};
        tbl[1]  = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001};
        tbl[2]  = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000};
        tbl[3]  = '{32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF};
        tbl[4]  = '{32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF};
        tbl[5]  = '{32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF};
        tbl[6]  = '{32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF};
        tbl[7]  = '{32'h1234_5678, 5'd4,  2'b00, 32'h2345_6780};
        tbl[8]  = '{32'hF000_0000, 5'd4,  2'b10, 32'hFF00_0000};
        tbl[9]  = '{32'hF000_0000, 5'd4,  2'b01, 32'h0F00_0000};
        tbl[10] = '{32'h7FFF_FFFF, 5'd30, 2'b10, 32'h0000_0001};
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        tbl[11] = '{32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000};
`else
        tbl[11] = '{32'h0000_0001, 5'd1,  2'b11, 32'h0000_0000};
`endif

        #12;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_data", out_data, 0);
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_out_valid8", 32'(ov8), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        latency_test("latency_sra", 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
        latency_test("latency_srl", 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001);

        streak = 0;
        best = 0;
        foreach (tbl[i]) send(tbl[i].data, tbl[i].sh, tbl[i].op, tbl[i].exp);
        drain();
        check("back_to_back_streak", best, 12);

        // Fill the pipe with the output blocked, then hold and release.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data  = $urandom;
            in_shamt = 5'($urandom);
            in_op    = 2'($urandom);
            send(in_data, in_shamt, in_op, model(in_data, in_shamt, in_op));
        end
        held = q[0];
        in_data  = 32'hCAFE_F00D;
        in_shamt = 5'd8;
        in_op    = 2'b01;
        cur_exp  = 32'h00CA_FEF0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_out_data", out_data, held);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 1);
        send(32'hCAFE_F00D, 5'd8, 2'b01, 32'h00CA_FEF0);
        drain();

        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_shamt  = 5'($urandom);
            in_op     = 2'($urandom);
            cur_exp   = model(in_data, in_shamt, in_op);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        // Reset while results are in flight, one already at the output.
        send(32'h0000_0001, 5'd0, 2'b00, 32'h0000_0001);
        send(32'h0000_0002, 5'd0, 2'b00, 32'h0000_0002);
        send(32'h0000_0003, 5'd0, 2'b00, 32'h0000_0003);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_reset_out_valid", 32'(out_valid), 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_out_valid", 32'(out_valid), 0);
        check("async_reset_out_data", out_data, 0);
        check("async_reset_in_ready", 32'(in_ready), 1);
        q.delete();
        out_ready = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (out_valid) seen++;
        end
        check("no_stale_result", seen, 0);

        v8 = 1'b1; d8 = 8'h90; sh8 = 3'd3; op8 = 2'b10;
        check("n8_in_ready", 32'(r8), 1);
        @(posedge clk);
        #1;
        v8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("n8_latency", lat, 3);
        check("n8_sra_data", 32'(od8), 32'h0000_00F2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
